uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (8N1 serializer, `wr`/`tx_data`/`busy` interface) between N byte requesters.
- Round-robin arbitration with optional packet locking: a requester keeps the transmitter until it sends a byte flagged `last`.
- Sequences the transmitter so `wr` is never asserted while a frame is in flight. A `wr` during a frame would corrupt it, because the transmitter restarts on `wr`.
- Sits between the CPU/IO byte sources and the transmitter in the top level.

Parameters:
- N, 4: number of requesters (2..8).
- LOCK_PACKETS, 1: 1 = hold grant until a byte with `req_last` = 1 is accepted; 0 = re-arbitrate after every byte.
- TIMEOUT, 65535: idle cycles a locked owner may go without `req_valid` before the lock is forcibly released; 0 disables the timeout.
- TW, 16: width of the timeout counter; TIMEOUT must fit in TW bits.

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N  requester i has a byte ready.
- req_data  in  8*N  byte for requester i at bits [8i+7:8i].
- req_last  in  N  byte is the final byte of a packet.
- req_ready  out  N  one-hot, combinational; handshake completes when `req_valid[i]` & `req_ready[i]`.
- tx_wr  out  1  registered one-cycle write strobe to the transmitter.
- tx_data  out  8  registered byte to the transmitter; stable from the `tx_wr` cycle until the next accept.
- tx_busy  in  1  transmitter busy flag; rises the cycle after `tx_wr`.
- owner  out  $clog2(N)  index of the last/current grantee.
- locked  out  1  a packet lock is held by `owner`.
- timeout_pulse  out  1  one-cycle pulse when a lock is force-released.

Behaviour:
- Reset values:
  - state = ARB
  - `tx_wr` = 0, `tx_data` = 8'h00, `owner` = 0, `locked` = 0, `timeout_pulse` = 0
  - round-robin pointer `rr` = 0, timeout counter = 0
  - `req_ready` = 0 whenever not in ARB.
- FSM states: ARB, ISSUE, SETTLE, DRAIN.
- ARB, accept only when `tx_busy` = 0:
  - If `locked`: `req_ready[owner]` = `req_valid[owner]`; no other requester is considered.
  - If not `locked`: grant goes to the first i with `req_valid[i]` scanning `rr`, `rr`+1, ... mod N; `req_ready[i]` = 1.
  - On accept:
    - `tx_data` <= `req_data[i]`; `owner` <= i.
    - `locked` <= LOCK_PACKETS & !`req_last[i]`.
    - If the new `locked` is 0, `rr` <= (i+1) mod N.
    - Go to ISSUE.
  - If `tx_busy` = 1 in ARB (e.g. after a reset mid-frame), no accept; wait.
- ISSUE: `tx_wr` = 1 for exactly this cycle. Next state SETTLE.
- SETTLE: one dead cycle that covers `tx_busy` latency. Next state DRAIN.
- DRAIN: wait for `tx_busy` = 0, then go to ARB. ARB may accept in that same cycle.
- Latency and throughput:
  - Accept to `tx_wr` is 1 cycle.
  - Minimum spacing between `tx_wr` pulses is frame length + 3 cycles.
  - No `tx_wr` is ever issued while `tx_busy` = 1.
- Timeout:
  - Counter increments each ARB cycle with `locked` = 1, `tx_busy` = 0 and `req_valid[owner]` = 0.
  - It clears on accept and whenever `locked` = 0.
  - When it reaches TIMEOUT (TIMEOUT != 0): `locked` <= 0, `rr` <= `owner`+1 mod N, `timeout_pulse` = 1 for one cycle, counter <= 0.
  - Arbitration uses the unlocked rules from the next cycle.
- Simultaneous events:
  - `req_valid` from several requesters: exactly one `req_ready` bit.
  - Timeout expiry coinciding with `req_valid[owner]` rising: the accept wins and there is no timeout.
- `req_last` is ignored when LOCK_PACKETS = 0.
- Mid-packet reset: the lock is dropped and `rr` = 0. In-flight requester state is the requester's problem. The transmitter frame in progress completes, and ARB holds off via `tx_busy`.
- `req_data`/`req_last` are sampled only in the accept cycle.

Decomposition:
- Shared package: FSM state encoding (ARB/ISSUE/SETTLE/DRAIN) and the 8-bit byte width constant.
- One natural sub-module: `rr_pick`, a combinational round-robin priority picker. Inputs are the request vector and `rr`; outputs are a one-hot grant and its index.
- Timeout counter and FSM stay in `uart_tx_arbiter`.

Test Plan:
- Reset, then requester 2 valid with 8'h41, `last` = 1, `tx_busy` low: `req_ready[2]` in cycle 0, `tx_wr` = 1 with `tx_data` = 8'h41 in cycle 1; `locked` stays 0; `rr` becomes 3.
- All 4 requesters continuously valid, LOCK_PACKETS = 0, transmitter model busy 4340 cycles per byte: grant order 0, 1, 2, 3, 0; `tx_wr` spacing ≥ 4343 cycles; `tx_busy` never high during `tx_wr`.
- Requester 1 sends 3-byte packet 8'h10, 8'h11, 8'h12 (`last` on third) while requester 0 is constantly valid: all three bytes go out back-to-back from requester 1, then requester 2/3/0 gets the grant per `rr`.
- TIMEOUT = 20, requester 3 sends a non-last byte then drops valid: after DRAIN, exactly 20 idle ARB cycles, then `timeout_pulse` is high for 1 cycle, `locked` = 0, and the next grant goes to the lowest valid index starting at 0.
- Reset asserted during DRAIN with the transmitter still busy: outputs return to reset values; no `tx_wr` and no `req_ready` until `tx_busy` falls; then a normal accept.
- Requester 0 valid in the same cycle the timeout would expire for locked owner 0: byte accepted, no `timeout_pulse`.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: FSM state encoding and byte width shared by the arbiter files
package uart_tx_arbiter_pkg;
  localparam int BW = 8;
  typedef enum logic [1:0] {ARB, ISSUE, SETTLE, DRAIN} state_t;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// uart_tx_arbiter_rr_pick: combinational round-robin picker, first set bit scanning from rr_i
// req_i request vector, rr_i scan start, gnt_o one-hot grant, idx_o grant index
module uart_tx_arbiter_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] rr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] j;
  // scanning backwards lets the candidate closest to rr_i overwrite the others
  always_comb begin
    j = '0;
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(rr_i) + k) % N);
      if (req_i[j]) idx_o = j;
    end
    gnt_o = |req_i ? N'(1) << idx_o : '0;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one 8N1 transmitter between N byte requesters, round-robin with packet locking
// clk_i/reset_i clock and sync active-high reset; req_valid_i/req_data_i/req_last_i/req_ready_o requester handshake;
// tx_wr_o/tx_data_o/tx_busy_i transmitter side; owner_o/locked_o/timeout_pulse_o grant status
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int LOCK_PACKETS = 1,
  parameter int TIMEOUT = 65535,
  parameter int TW = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [N-1:0]         req_valid_i,
  input  logic [BW*N-1:0]      req_data_i,
  input  logic [N-1:0]         req_last_i,
  output logic [N-1:0]         req_ready_o,
  output logic                 tx_wr_o,
  output logic [BW-1:0]        tx_data_o,
  input  logic                 tx_busy_i,
  output logic [$clog2(N)-1:0] owner_o,
  output logic                 locked_o,
  output logic                 timeout_pulse_o
);
  localparam int IW = $clog2(N);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, owner_q, owner_d, idx;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] data_q, data_d;
  logic [N-1:0] cand, gnt;
  logic wr_q, locked_q, locked_d, pulse_q, arb_ok, accept, idle, expire, new_lock;
  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] v);
    return v == IW'(N - 1) ? '0 : v + 1'b1;
  endfunction
  // a held lock narrows the candidates to the owner alone
  assign cand = locked_q ? req_valid_i & (N'(1) << owner_q) : req_valid_i;
  uart_tx_arbiter_rr_pick #(.N(N)) u_pick (
    .req_i(cand),
    .rr_i (rr_q),
    .gnt_o(gnt),
    .idx_o(idx)
  );
  always_comb begin
    arb_ok = state_q == ARB && !tx_busy_i;
    accept = arb_ok && |cand;
    req_ready_o = arb_ok ? gnt : '0;
    // an owner that turns valid in the expiry cycle is accepted, so idle excludes it
    idle = arb_ok && locked_q && !req_valid_i[owner_q];
    expire = TIMEOUT != 0 && idle && cnt_q == TO_LAST;
    new_lock = LOCK_PACKETS != 0 && !req_last_i[idx];
    state_d = state_q == ARB ? (accept ? ISSUE : ARB) :
              state_q == ISSUE ? SETTLE :
              state_q == SETTLE ? DRAIN : (tx_busy_i ? DRAIN : ARB);
    data_d = accept ? req_data_i[BW*idx +: BW] : data_q;
    owner_d = accept ? idx : owner_q;
    locked_d = accept ? new_lock : locked_q && !expire;
    rr_d = accept && !new_lock ? nxt(idx) : expire ? nxt(owner_q) : rr_q;
    cnt_d = accept || expire || !locked_q ? '0 : idle ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ARB;
      wr_q <= 1'b0;
      data_q <= '0;
      owner_q <= '0;
      locked_q <= 1'b0;
      pulse_q <= 1'b0;
      rr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q <= accept;
      data_q <= data_d;
      owner_q <= owner_d;
      locked_q <= locked_d;
      pulse_q <= expire;
      rr_q <= rr_d;
      cnt_q <= cnt_d;
    end
  end
  assign tx_wr_o = wr_q;
  assign tx_data_o = data_q;
  assign owner_o = owner_q;
  assign locked_o = locked_q;
  assign timeout_pulse_o = pulse_q;
endmodule
